// File: rtl/decode_execute_reg_if.sv
// Bundle of D->E pipeline signals, upstream control and E register outputs.
// master drives the D/d-side inputs and observes E/control; slave is the register.
interface decode_execute_reg_if;
   logic [3:0]         D_Ins_Code;
   logic [3:0]         D_Ins_fun;
   logic [2:0]         d_stat;
   logic signed [63:0] D_Val_C;
   logic signed [63:0] d_value_A;
   logic signed [63:0] d_value_B;
   logic [3:0]         d_srcA;
   logic [3:0]         d_srcB;
   logic [3:0]         d_dstE;
   logic [3:0]         d_dstM;
   logic [3:0]         M_Ins_Code;
   logic               e_Cnd;
   logic [2:0]         W_stat;

   logic [3:0]         E_Ins_Code;
   logic [3:0]         E_Ins_fun;
   logic [2:0]         E_stat;
   logic signed [63:0] E_Val_C;
   logic signed [63:0] E_value_A;
   logic signed [63:0] E_value_B;
   logic [3:0]         E_srcA;
   logic [3:0]         E_srcB;
   logic [3:0]         E_dstE;
   logic [3:0]         E_dstM;
   logic               F_stall;
   logic               D_stall;
   logic               D_bubble;

   modport master (
      output D_Ins_Code, D_Ins_fun, d_stat, D_Val_C, d_value_A, d_value_B,
             d_srcA, d_srcB, d_dstE, d_dstM, M_Ins_Code, e_Cnd, W_stat,
      input  E_Ins_Code, E_Ins_fun, E_stat, E_Val_C, E_value_A, E_value_B,
             E_srcA, E_srcB, E_dstE, E_dstM, F_stall, D_stall, D_bubble
   );

   modport slave (
      input  D_Ins_Code, D_Ins_fun, d_stat, D_Val_C, d_value_A, d_value_B,
             d_srcA, d_srcB, d_dstE, d_dstM, M_Ins_Code, e_Cnd, W_stat,
      output E_Ins_Code, E_Ins_fun, E_stat, E_Val_C, E_value_A, E_value_B,
             E_srcA, E_srcB, E_dstE, E_dstM, F_stall, D_stall, D_bubble
   );
endinterface

// File: rtl/decode_execute_reg.sv
// Y86-64 D->E pipeline register with hazard detection and upstream stall/bubble control.
// Optional feature: define HAZARD_STATS_EN to add saturating 32-bit hazard counters.
module decode_execute_reg #(
   parameter logic [3:0] NOP_CODE = 4'd1,
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [2:0] STAT_AOK = 3'd1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decode_execute_reg_if.slave  bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]          loaduse_count,
   output logic [31:0]          mispredict_count,
   output logic [31:0]          ret_stall_count
`endif
);

   localparam logic [3:0] IMRMOVQ = 4'd5;
   localparam logic [3:0] IJXX    = 4'd7;
   localparam logic [3:0] IRET    = 4'd9;
   localparam logic [3:0] IPOPQ   = 4'd11;

   logic [3:0]         icode_q, ifun_q;
   logic [2:0]         stat_q;
   logic signed [63:0] valc_q, vala_q, valb_q;
   logic [3:0]         srca_q, srcb_q, dste_q, dstm_q;

   logic load_use, mispredict, ret_haz, halt_freeze, e_bubble;

   // Hazard terms from the current E contents and incoming decode fields
   always_comb begin
      load_use    = ((icode_q == IMRMOVQ) || (icode_q == IPOPQ)) && (dstm_q != RNONE) &&
                    ((dstm_q == bus.d_srcA) || (dstm_q == bus.d_srcB));
      mispredict  = (icode_q == IJXX) && !bus.e_Cnd;
      ret_haz     = (bus.D_Ins_Code == IRET) || (icode_q == IRET) || (bus.M_Ins_Code == IRET);
      halt_freeze = (bus.W_stat != STAT_AOK);
      e_bubble    = mispredict || load_use;
   end

   // Upstream control; a non-AOK status in W freezes fetch/decode and suppresses bubbles
   always_comb begin
      if (halt_freeze) begin
         bus.F_stall  = 1'b1;
         bus.D_stall  = 1'b1;
         bus.D_bubble = 1'b0;
      end else begin
         bus.F_stall  = load_use || ret_haz;
         bus.D_stall  = load_use;
         bus.D_bubble = mispredict || (ret_haz && !load_use);
      end
   end

   // E register: freeze holds, bubble loads a nop, otherwise capture decode outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icode_q <= NOP_CODE;
         ifun_q  <= 4'd0;
         stat_q  <= STAT_AOK;
         valc_q  <= '0;
         vala_q  <= '0;
         valb_q  <= '0;
         srca_q  <= RNONE;
         srcb_q  <= RNONE;
         dste_q  <= RNONE;
         dstm_q  <= RNONE;
      end else if (halt_freeze) begin
         icode_q <= icode_q;
      end else if (e_bubble) begin
         icode_q <= NOP_CODE;
         ifun_q  <= 4'd0;
         stat_q  <= STAT_AOK;
         valc_q  <= '0;
         vala_q  <= '0;
         valb_q  <= '0;
         srca_q  <= RNONE;
         srcb_q  <= RNONE;
         dste_q  <= RNONE;
         dstm_q  <= RNONE;
      end else begin
         icode_q <= bus.D_Ins_Code;
         ifun_q  <= bus.D_Ins_fun;
         stat_q  <= bus.d_stat;
         valc_q  <= bus.D_Val_C;
         vala_q  <= bus.d_value_A;
         valb_q  <= bus.d_value_B;
         srca_q  <= bus.d_srcA;
         srcb_q  <= bus.d_srcB;
         dste_q  <= bus.d_dstE;
         dstm_q  <= bus.d_dstM;
      end
   end

   // Drive the E register onto the bus
   always_comb begin
      bus.E_Ins_Code = icode_q;
      bus.E_Ins_fun  = ifun_q;
      bus.E_stat     = stat_q;
      bus.E_Val_C    = valc_q;
      bus.E_value_A  = vala_q;
      bus.E_value_B  = valb_q;
      bus.E_srcA     = srca_q;
      bus.E_srcB     = srcb_q;
      bus.E_dstE     = dste_q;
      bus.E_dstM     = dstm_q;
   end

`ifdef HAZARD_STATS_EN
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // Saturating hazard counters, idle while the pipeline is frozen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaduse_count    <= '0;
         mispredict_count <= '0;
         ret_stall_count  <= '0;
      end else if (!halt_freeze) begin
         if (load_use && (loaduse_count != CNT_MAX)) begin
            loaduse_count <= loaduse_count + 32'd1;
         end
         if (mispredict && (mispredict_count != CNT_MAX)) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
         if (ret_haz && (ret_stall_count != CNT_MAX)) begin
            ret_stall_count <= ret_stall_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: driver pushes expectations, monitor compares.
module tb_decode_execute_reg;

   logic clk;
   logic rst_n;

   decode_execute_reg_if bus ();

`ifdef HAZARD_STATS_EN
   logic [31:0] loaduse_count, mispredict_count, ret_stall_count;
`endif

   decode_execute_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef HAZARD_STATS_EN
      ,
      .loaduse_count    (loaduse_count),
      .mispredict_count (mispredict_count),
      .ret_stall_count  (ret_stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode, ifun;
      logic [2:0]  stat;
      logic [63:0] valc, vala, valb;
      logic [3:0]  srca, srcb, dste, dstm;
   } e_t;

   typedef struct {
      e_t          d;
      logic [3:0]  micode;
      logic        cnd;
      logic [2:0]  wstat;
   } in_t;

   typedef struct {
      e_t   e;
      logic fs, ds, db;
   } exp_t;

   exp_t        sb[$];
   e_t          m;          // reference E register
   logic [3:0]  m_stage;    // what the reference pipeline holds in M
   bit          auto_m;
   int unsigned n_lu, n_mp, n_ret;
   int          checks, errors;

   function automatic e_t nop_e();
      e_t r;
      r.icode = 4'd1; r.ifun = 4'd0; r.stat = 3'd1;
      r.valc = '0; r.vala = '0; r.valb = '0;
      r.srca = 4'hF; r.srcb = 4'hF; r.dste = 4'hF; r.dstm = 4'hF;
      return r;
   endfunction

   function automatic in_t def_in();
      in_t x;
      x.d = nop_e();
      x.micode = 4'd1;
      x.cnd = 1'b1;
      x.wstat = 3'd1;
      return x;
   endfunction

   function automatic in_t rand_in();
      in_t x;
      x.d.icode = 4'($urandom_range(0, 11));
      x.d.ifun  = 4'($urandom_range(0, 15));
      x.d.stat  = 3'($urandom_range(1, 4));
      x.d.valc  = {$urandom, $urandom};
      x.d.vala  = {$urandom, $urandom};
      x.d.valb  = {$urandom, $urandom};
      x.d.srca  = 4'($urandom_range(0, 4));
      x.d.srcb  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      x.d.dste  = 4'($urandom_range(0, 15));
      x.d.dstm  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      x.micode  = 4'($urandom_range(0, 11));
      x.cnd     = 1'($urandom_range(0, 1));
      x.wstat   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: apply inputs, push what this cycle must show, advance the model
   task automatic drive(input in_t x);
      exp_t ex;
      bit   lu, mp, rh, hf;
      @(posedge clk);
      #1;
      if (auto_m) x.micode = m_stage;
      bus.D_Ins_Code = x.d.icode;  bus.D_Ins_fun = x.d.ifun;  bus.d_stat = x.d.stat;
      bus.D_Val_C = x.d.valc;      bus.d_value_A = x.d.vala;  bus.d_value_B = x.d.valb;
      bus.d_srcA = x.d.srca;       bus.d_srcB = x.d.srcb;
      bus.d_dstE = x.d.dste;       bus.d_dstM = x.d.dstm;
      bus.M_Ins_Code = x.micode;   bus.e_Cnd = x.cnd;         bus.W_stat = x.wstat;

      lu = (m.icode == 4'd5 || m.icode == 4'd11) && m.dstm != 4'hF &&
           (m.dstm == x.d.srca || m.dstm == x.d.srcb);
      mp = (m.icode == 4'd7) && !x.cnd;
      rh = (x.d.icode == 4'd9) || (m.icode == 4'd9) || (x.micode == 4'd9);
      hf = (x.wstat != 3'd1);

      ex.e  = m;
      ex.fs = hf ? 1'b1 : (lu || rh);
      ex.ds = hf ? 1'b1 : lu;
      ex.db = hf ? 1'b0 : (mp || (rh && !lu));
      sb.push_back(ex);

      if (!hf) begin
         m_stage = m.icode;
         if (lu && n_lu != 32'hFFFF_FFFF) n_lu++;
         if (mp && n_mp != 32'hFFFF_FFFF) n_mp++;
         if (rh && n_ret != 32'hFFFF_FFFF) n_ret++;
         m = (lu || mp) ? nop_e() : x.d;
      end
   endtask

   task automatic chk_e(input string tag, input e_t e);
      chk({tag, ".icode"}, 64'(bus.E_Ins_Code), 64'(e.icode));
      chk({tag, ".ifun"},  64'(bus.E_Ins_fun),  64'(e.ifun));
      chk({tag, ".stat"},  64'(bus.E_stat),     64'(e.stat));
      chk({tag, ".valc"},  bus.E_Val_C,         e.valc);
      chk({tag, ".vala"},  bus.E_value_A,       e.vala);
      chk({tag, ".valb"},  bus.E_value_B,       e.valb);
      chk({tag, ".srca"},  64'(bus.E_srcA),     64'(e.srca));
      chk({tag, ".srcb"},  64'(bus.E_srcB),     64'(e.srcb));
      chk({tag, ".dste"},  64'(bus.E_dstE),     64'(e.dste));
      chk({tag, ".dstm"},  64'(bus.E_dstM),     64'(e.dstm));
   endtask

   // Monitor: every falling edge with a pending expectation, compare E and control outputs
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t ex;
         ex = sb.pop_front();
         chk_e("e", ex.e);
         chk("F_stall",  64'(bus.F_stall),  64'(ex.fs));
         chk("D_stall",  64'(bus.D_stall),  64'(ex.ds));
         chk("D_bubble", 64'(bus.D_bubble), 64'(ex.db));
      end
   end

   task automatic reset_model();
      m = nop_e();
      m_stage = 4'd1;
      n_lu = 0; n_mp = 0; n_ret = 0;
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk_counts();
      chk("loaduse_count",    64'(loaduse_count),    64'(n_lu));
      chk("mispredict_count", 64'(mispredict_count), 64'(n_mp));
      chk("ret_stall_count",  64'(ret_stall_count),  64'(n_ret));
   endtask
`endif

   initial begin
      in_t x;
      checks = 0; errors = 0; auto_m = 1'b1;
      x = def_in();
      bus.D_Ins_Code = x.d.icode; bus.D_Ins_fun = 4'd0; bus.d_stat = 3'd1;
      bus.D_Val_C = '0; bus.d_value_A = '0; bus.d_value_B = '0;
      bus.d_srcA = 4'hF; bus.d_srcB = 4'hF; bus.d_dstE = 4'hF; bus.d_dstM = 4'hF;
      bus.M_Ins_Code = 4'd1; bus.e_Cnd = 1'b1; bus.W_stat = 3'd1;
      reset_model();
      rst_n = 1'b0;
      #12;
      chk_e("reset", nop_e());
      #1 rst_n = 1'b1;

      // Pass-through
      x = def_in();
      x.d.icode = 4'd6; x.d.valc = 64'd0; x.d.vala = 64'd5; x.d.valb = -64'sd3; x.d.dste = 4'd2;
      drive(x);
      drive(def_in());

      // Load/use: mrmovq with dstM=3, then a consumer of r3 held for one extra cycle
      x = def_in(); x.d.icode = 4'd5; x.d.dstm = 4'd3;
      drive(x);
      x = def_in(); x.d.icode = 4'd6; x.d.srcb = 4'd3; x.d.dste = 4'd3;
      drive(x);
      drive(x);
      drive(def_in());

      // Mispredicted jump
      x = def_in(); x.d.icode = 4'd7;
      drive(x);
      x = def_in(); x.cnd = 1'b0; x.d.icode = 4'd6; x.d.vala = 64'd77;
      drive(x);
      drive(def_in());

      // ret walking D->E->M
      x = def_in(); x.d.icode = 4'd9;
      drive(x);
      drive(def_in());
      drive(def_in());
      drive(def_in());

      // Halt freeze with changing inputs
      x = def_in(); x.d.icode = 4'd3; x.d.valc = 64'd42; x.d.dste = 4'd1;
      drive(x);
      for (int i = 0; i < 5; i++) begin
         x = rand_in(); x.wstat = 3'd2;
         drive(x);
      end
      drive(def_in());

      // Randomized traffic
      auto_m = 1'b0;
      for (int i = 0; i < 400; i++) drive(rand_in());

      // Mid-cycle reset after non-trivial state
      x = def_in(); x.d.icode = 4'd6; x.d.vala = 64'd9; x.d.dste = 4'd4; x.d.stat = 3'd2;
      drive(x);
      drive(def_in());
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_e("midreset", nop_e());
      reset_model();
`ifdef HAZARD_STATS_EN
      chk_counts();
`endif
      #1 rst_n = 1'b1;
      for (int i = 0; i < 60; i++) drive(rand_in());

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
`ifdef HAZARD_STATS_EN
      chk_counts();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Pipeline register between the Decode and Execute stages of the Y86-64 five-stage pipeline, plus the pipeline-control logic that governs it. It latches the decoded instruction fields and the forwarded operands (d_value_A, d_value_B) into the E_ register on each rising clock edge. It detects load/use, mispredicted-branch and ret hazards, inserts bubbles into E, and drives stall and bubble requests to the Fetch and F/D registers. It also freezes the pipeline once a non-AOK status reaches Write-back.

## Interface
Parameters:
- NOP_CODE, 4'd1: icode loaded into E on reset or bubble.
- RNONE, 4'hF: "no register" encoding.
- STAT_AOK, 3'd1: status value meaning normal operation.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_Ins_Code, D_Ins_fun  in  4 each  icode/ifun held in the D register.
- d_stat  in  3  status produced by Decode.
- D_Val_C  in  64 signed  constant word.
- d_value_A, d_value_B  in  64 signed  forwarded operands from Decode.
- d_srcA, d_srcB, d_dstE, d_dstM  in  4 each  register IDs from Decode.
- M_Ins_Code  in  4  icode currently in the M register.
- e_Cnd  in  1  branch condition computed in Execute.
- W_stat  in  3  status in the W register.
- E_Ins_Code, E_Ins_fun  out  4 each  registered icode/ifun.
- E_stat  out  3  registered status.
- E_Val_C, E_value_A, E_value_B  out  64 signed  registered values.
- E_srcA, E_srcB, E_dstE, E_dstM  out  4 each  registered register IDs.
- F_stall, D_stall, D_bubble  out  1 each  combinational control to upstream registers.

## Operation
Hazard terms, computed combinationally from the E_ outputs and the inputs:
- load_use = (E_Ins_Code==5 or E_Ins_Code==11) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
- mispredict = E_Ins_Code==7 and !e_Cnd.
- ret_haz = 9 appears in D_Ins_Code, E_Ins_Code or M_Ins_Code.
- halt_freeze = W_stat != STAT_AOK.

Control outputs:
- F_stall = load_use or ret_haz.
- D_stall = load_use.
- D_bubble = mispredict or (ret_haz and !load_use).
- When halt_freeze is high, F_stall and D_stall are forced to 1 and D_bubble is forced to 0.

E register update on each rising clk, highest priority first:
1. halt_freeze: hold all E_ outputs.
2. E_bubble = mispredict or load_use: load bubble values.
3. Otherwise: load all D/d inputs into the matching E_ outputs.

Bubble values (identical to the reset values):
- E_Ins_Code = NOP_CODE; E_Ins_fun = 0; E_stat = STAT_AOK.
- E_Val_C, E_value_A, E_value_B = 0.
- All four register IDs = RNONE.

Other rules:
- Values are passed through unchanged; there is no arithmetic and no width conversion.

## Timing
- Latency: exactly one cycle from the D/d inputs to the E_ outputs.
- F_stall, D_stall and D_bubble are purely combinational. They are valid in the same cycle as their inputs, with no zero-delay or #-delay dependence.
- Asynchronous reset: rst_n low immediately forces all E_ outputs to their reset values, including mid-cycle. Deassertion takes effect at the next rising clk.
- Simultaneous load_use and mispredict: E is bubbled, D_stall=1 and D_bubble=1. The F/D register gives stall priority.
- Simultaneous load_use and ret_haz: F_stall=1, D_stall=1, D_bubble=0.
- A bubble lasts exactly one cycle per hazard occurrence. A load_use stall on its own never extends beyond one cycle.

## Configuration
- HAZARD_STATS_EN defined: the block adds three output ports, each 32 bits: loaduse_count, mispredict_count, ret_stall_count.
  - Each counter increments on a rising clk in which its term is high and halt_freeze is low.
  - Each counter saturates at 32'hFFFFFFFF.
  - rst_n clears all three to 0.
- HAZARD_STATS_EN undefined: the ports and the counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset: rst_n=0 mid-cycle → E_Ins_Code=1, E_stat=1, E_dstE=E_dstM=E_srcA=E_srcB=15 and all values 0, without waiting for a clock edge.
- Pass-through: D_Ins_Code=6, D_Val_C=0, d_value_A=5, d_value_B=-3, d_dstE=2 → after one edge E_Ins_Code=6, E_value_A=5, E_value_B=-3, E_dstE=2; all control outputs 0.
- Load/use: E holds mrmovq with E_dstM=3 and d_srcB=3 → F_stall=1 and D_stall=1. The next edge puts a nop in E. The following edge loads the held instruction.
- Mispredict: E_Ins_Code=7 with e_Cnd=0 → D_bubble=1 and E bubbled. Counter mispredict_count=1 when HAZARD_STATS_EN is defined.
- Ret: D_Ins_Code=9 → F_stall=1 and D_bubble=1 for 3 consecutive cycles as the ret moves D→E→M.
- Halt freeze: W_stat=2 → E_ outputs hold for 5 cycles with changing inputs; F_stall=D_stall=1 and D_bubble=0.
